// File: rtl/jpeg_block_sequencer.sv
// Streams an image into jpeg_top as back-to-back 64-pixel blocks, then drains the encoder
// until its final partial-word flush, and reports completion/error status.
module jpeg_block_sequencer #(
    parameter int unsigned BLK_CNT_W     = 16,
    parameter int unsigned DRAIN_TIMEOUT = 4096,
    parameter int unsigned WORD_CNT_W    = 24
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [BLK_CNT_W-1:0]  i_num_blocks,
    input  logic                  i_pix_valid,
    input  logic [23:0]           i_pix_data,
    output logic                  o_pix_ready,
    output logic                  o_enc_enable,
    output logic [23:0]           o_enc_data,
    output logic                  o_enc_eof,
    input  logic                  i_enc_data_ready,
    input  logic                  i_enc_eof_partial,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_underrun_err,
    output logic                  o_timeout_err,
    output logic [BLK_CNT_W-1:0]  o_block_idx,
    output logic [WORD_CNT_W-1:0] o_word_count
);

    localparam int unsigned TMR_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]      TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]      TMR_ONE  = TMR_W'(1);
    localparam logic [BLK_CNT_W-1:0]  BLK_ONE  = BLK_CNT_W'(1);
    localparam logic [WORD_CNT_W-1:0] WC_ONE   = WORD_CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StDone
    } state_t;

    state_t                r_state;
    logic [BLK_CNT_W-1:0]  r_num_blocks;
    logic [BLK_CNT_W-1:0]  r_block_idx;
    logic [5:0]            r_pix_cnt;
    logic [TMR_W-1:0]      r_timer;
    logic [WORD_CNT_W-1:0] r_word_count;
    logic                  r_enc_enable;
    logic [23:0]           r_enc_data;
    logic                  r_enc_eof;
    logic                  r_done;
    logic                  r_underrun_err;
    logic                  r_timeout_err;

    logic w_last_blk;
    logic w_last_slot;
    logic w_timer_exp;
    logic w_wc_sat;
    logic w_count_word;

    assign w_last_blk   = (r_block_idx == r_num_blocks - BLK_ONE);
    assign w_last_slot  = (r_pix_cnt == 6'd63);
    assign w_timer_exp  = (r_timer == TMR_LAST);
    assign w_wc_sat     = &r_word_count;
    assign w_count_word = i_enc_data_ready && (r_state != StIdle) && !w_wc_sat;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_num_blocks   <= '0;
            r_block_idx    <= '0;
            r_pix_cnt      <= '0;
            r_timer        <= '0;
            r_word_count   <= '0;
            r_enc_enable   <= 1'b0;
            r_enc_data     <= '0;
            r_enc_eof      <= 1'b0;
            r_done         <= 1'b0;
            r_underrun_err <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_count_word) begin
                r_word_count <= r_word_count + WC_ONE;
            end
            unique case (r_state)
                StIdle: begin
                    r_enc_enable <= 1'b0;
                    r_enc_eof    <= 1'b0;
                    if (i_start) begin
                        if (i_num_blocks != '0) begin
                            r_num_blocks   <= i_num_blocks;
                            r_pix_cnt      <= '0;
                            r_block_idx    <= '0;
                            r_word_count   <= '0;
                            r_underrun_err <= 1'b0;
                            r_timeout_err  <= 1'b0;
                            r_state        <= StFeed;
                        end else begin
                            r_state <= StDone;
                        end
                    end
                end
                StFeed: begin
                    // The encoder cannot stall mid-block, so a missing pixel still uses its slot.
                    r_enc_enable <= 1'b1;
                    r_enc_eof    <= w_last_blk;
                    if (i_pix_valid) begin
                        r_enc_data <= i_pix_data;
                    end else begin
                        r_underrun_err <= 1'b1;
                    end
                    r_pix_cnt <= r_pix_cnt + 6'd1;
                    if (w_last_slot) begin
                        r_block_idx <= r_block_idx + BLK_ONE;
                        if (w_last_blk) begin
                            r_timer <= '0;
                            r_state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    r_enc_enable <= 1'b1;
                    r_enc_data   <= '0;
                    r_enc_eof    <= 1'b0;
                    r_timer      <= r_timer + TMR_ONE;
                    // A flush arriving on the expiry cycle still counts as success.
                    if (i_enc_eof_partial) begin
                        r_state <= StDone;
                    end else if (w_timer_exp) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= StDone;
                    end
                end
                StDone: begin
                    r_enc_enable <= 1'b0;
                    r_done       <= 1'b1;
                    r_state      <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_pix_ready    = (r_state == StFeed);
    assign o_busy         = (r_state == StFeed) || (r_state == StDrain);
    assign o_enc_enable   = r_enc_enable;
    assign o_enc_data     = r_enc_data;
    assign o_enc_eof      = r_enc_eof;
    assign o_done         = r_done;
    assign o_underrun_err = r_underrun_err;
    assign o_timeout_err  = r_timeout_err;
    assign o_block_idx    = r_block_idx;
    assign o_word_count   = r_word_count;

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Randomized scoreboard bench for jpeg_block_sequencer: encoder words are predicted per slot
// from the image model and checked by an independent monitor.
module tb_jpeg_block_sequencer;

    localparam int unsigned BW = 16;
    localparam int unsigned TO = 16;
    localparam int unsigned WW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BW-1:0] num_blocks;
    logic          pix_valid;
    logic [23:0]   pix_data;
    logic          pix_ready;
    logic          enc_enable;
    logic [23:0]   enc_data;
    logic          enc_eof;
    logic          enc_data_ready;
    logic          enc_eof_partial;
    logic          busy;
    logic          done;
    logic          underrun_err;
    logic          timeout_err;
    logic [BW-1:0] block_idx;
    logic [WW-1:0] word_count;

    jpeg_block_sequencer #(
        .BLK_CNT_W    (BW),
        .DRAIN_TIMEOUT(TO),
        .WORD_CNT_W   (WW)
    ) u_dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_start          (start),
        .i_num_blocks     (num_blocks),
        .i_pix_valid      (pix_valid),
        .i_pix_data       (pix_data),
        .o_pix_ready      (pix_ready),
        .o_enc_enable     (enc_enable),
        .o_enc_data       (enc_data),
        .o_enc_eof        (enc_eof),
        .i_enc_data_ready (enc_data_ready),
        .i_enc_eof_partial(enc_eof_partial),
        .o_busy           (busy),
        .o_done           (done),
        .o_underrun_err   (underrun_err),
        .o_timeout_err    (timeout_err),
        .o_block_idx      (block_idx),
        .o_word_count     (word_count)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    logic [24:0] exp_q[$];
    logic [23:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every enabled encoder cycle must match the next predicted {eof, data}.
    always @(negedge clk) begin
        if (!rst && enc_enable) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL enc_word_extra: got eof=%0b data=0x%0h, expected no word (t=%0t)",
                         enc_eof, enc_data, $time);
            end else begin
                check("enc_word", {7'd0, enc_eof, enc_data}, {7'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_start(input logic [BW-1:0] n);
        @(negedge clk);
        start      = 1'b1;
        num_blocks = n;
        @(negedge clk);
        start      = 1'b0;
        num_blocks = '0;
    endtask

    // mode: 0 = all pixels valid, 1 = only pixel 10 missing, 2 = random gaps.
    // j: drain cycle at which the flush arrives (j >= TO means never).
    task automatic run_image(input int n, input int mode, input int j, input int rd_pct,
                             input bit extra_start, input int rst_slot);
        int slot  = 0;
        int drain = 0;
        int wc    = 0;
        int m;
        bit und   = 1'b0;
        bit fin   = 1'b0;
        bit valid;
        m = (j < int'(TO)) ? j + 1 : int'(TO);
        do_start(BW'(n));
        for (int cyc = 0; cyc < 64 * n + int'(TO) + 8 && !fin; cyc++) begin
            enc_data_ready  = ($urandom_range(99) < rd_pct);
            enc_eof_partial = 1'b0;
            start           = 1'b0;
            if (pix_ready) begin
                check("block_idx", 32'(block_idx), 32'(slot / 64));
                if (slot == rst_slot) begin
                    #1 rst = 1'b1;
                    #1;
                    check("rst_pix_ready", 32'(pix_ready), 32'd0);
                    check("rst_enc_enable", 32'(enc_enable), 32'd0);
                    check("rst_busy", 32'(busy), 32'd0);
                    exp_q.delete();
                    last_data       = '0;
                    enc_data_ready  = 1'b0;
                    pix_valid       = 1'b0;
                    @(negedge clk);
                    check("rst_done", 32'(done), 32'd0);
                    check("rst_word_count", 32'(word_count), 32'd0);
                    rst = 1'b0;
                    return;
                end
                valid = (mode == 0) ? 1'b1 : (mode == 1) ? (slot != 10) : ($urandom_range(7) != 0);
                pix_valid = valid;
                pix_data  = (mode == 0 && n == 1) ? 24'(slot) : 24'($urandom);
                if (valid) last_data = pix_data;
                else und = 1'b1;
                exp_q.push_back({(slot >= 64 * (n - 1)), last_data});
                enc_eof_partial = 1'($urandom_range(1));
                if (extra_start && slot == 70) begin
                    start      = 1'b1;
                    num_blocks = BW'(5);
                end
                wc += int'(enc_data_ready);
                slot++;
            end else if (busy) begin
                pix_valid = 1'b0;
                if (drain == 0) begin
                    for (int k = 0; k < m; k++) exp_q.push_back('0);
                    last_data = '0;
                end
                if (drain == j) enc_eof_partial = 1'b1;
                wc += int'(enc_data_ready);
                drain++;
            end else begin
                wc += int'(enc_data_ready);
                fin = 1'b1;
            end
            if (!fin) @(negedge clk);
        end
        enc_eof_partial = 1'b0;
        check("image_finished", 32'(fin), 32'd1);
        check("feed_slots", 32'(slot), 32'(64 * n));
        check("drain_cycles", 32'(drain), 32'(m));
        check("done_early", 32'(done), 32'd0);
        @(negedge clk);
        enc_data_ready = 1'($urandom_range(1));
        check("done_pulse", 32'(done), 32'd1);
        check("underrun_err", 32'(underrun_err), 32'(und));
        check("timeout_err", 32'(timeout_err), 32'(j >= int'(TO)));
        check("word_count", 32'(word_count), 32'((wc > 255) ? 255 : wc));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        enc_data_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_blocks = '0; pix_valid = 1'b0; pix_data = '0;
        enc_data_ready = 1'b0; enc_eof_partial = 1'b0;
        #12;
        check("reset_enable", 32'(enc_enable), 32'd0);
        check("reset_busy_ready", {30'd0, busy, pix_ready}, 32'd0);
        check("reset_word_count", 32'(word_count), 32'd0);
        check("reset_block_idx", 32'(block_idx), 32'd0);
        check("reset_flags", {29'd0, done, underrun_err, timeout_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_image(1, 0, 5, 100, 1'b0, -1);
        run_image(3, 0, 3, 50, 1'b0, -1);
        run_image(2, 1, 8, 50, 1'b0, -1);
        run_image(1, 0, 20, 50, 1'b0, -1);

        // Empty image: done two cycles after start, encoder untouched.
        do_start('0);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("zero_done", 32'(done), 32'd1);
        @(negedge clk);
        check("zero_done_single", 32'(done), 32'd0);

        run_image(2, 0, 0, 50, 1'b1, -1);
        run_image(2, 0, 4, 50, 1'b0, 30);
        run_image(1, 0, int'(TO) - 1, 100, 1'b0, -1);
        run_image(4, 0, 2, 100, 1'b0, -1);

        for (int i = 0; i < 8; i++) begin
            run_image(int'($urandom_range(3, 1)), int'($urandom_range(2)),
                      int'($urandom_range(TO + 3)), int'($urandom_range(100)),
                      1'($urandom_range(1)), -1);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
